// File: rtl/ofmd_stream_out.sv
// rtl/ofmd_stream_out.sv - streams one OFMD frame from memory onto a ready/valid output
module ofmd_stream_out #(
  parameter int WIDTH      = 6,
  parameter int DATA_W     = 16,
  parameter int OFMD1_SIZE = 36,
  parameter int OFMD2_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_5x5,
  output logic              mem_rd_en,
  output logic [WIDTH-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   issue_cnt;
  logic [WIDTH-1:0]   out_cnt;
  logic [WIDTH-1:0]   last_idx;
  logic               inflight;
  logic [1:0]         count;
  logic [DATA_W-1:0]  fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Issue only while the two-entry buffer is guaranteed room for the returning word:
  // count + inflight - pop < 2, rearranged to avoid an unsigned underflow.
  assign mem_rd_en   = (state == RUN) &&
                       (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign mem_rd_addr = mem_rd_en ? issue_cnt : '0;

  assign out_data = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last = out_valid && (out_cnt == last_idx);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Frame sequencing: frame size latch, read issue counter and output beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      out_cnt   <= '0;
      last_idx  <= '0;
    end else begin
      if (pop) begin
        out_cnt <= out_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            last_idx  <= is_5x5 ? WIDTH'(OFMD2_SIZE - 1) : WIDTH'(OFMD1_SIZE - 1);
            issue_cnt <= '0;
            out_cnt   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (mem_rd_en) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == last_idx) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry buffer: capture read data one cycle after the strobe, pop on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (inflight) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ofmd_stream_out.sv
// tb/tb_ofmd_stream_out.sv - directed self-checking bench for ofmd_stream_out
module tb_ofmd_stream_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_5x5;
  logic        mem_rd_en;
  logic [5:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  ofmd_stream_out dut (
    .clk(clk), .rst(rst), .start(start), .is_5x5(is_5x5),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, returns addr + 0x100
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 16'h100 + 16'(mem_rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready=1, mode 1: ready=0 for 10 cycles from first valid,
  // mode 2: random ready plus random start/is_5x5 noise during the frame
  task automatic frame(input bit is5, input int mode, input int abort_at);
    int n = is5 ? 16 : 36;
    int beats = 0, lasts = 0, dones = 0, issued = 0, max_out = 0;
    int first_v = 0, last_hs = 0;
    bit fin = 0;
    @(negedge clk);
    is_5x5 = is5; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 600 && !fin; k++) begin
      if (k > 1) @(negedge clk);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (k >= 13);
        2: begin
          out_ready = 1'($urandom_range(0, 1));
          start     = 1'($urandom_range(0, 1));
          is_5x5    = 1'($urandom_range(0, 1));
        end
        default: out_ready = 1'b1;
      endcase
      #1;
      if (abort_at > 0 && beats == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_async_outs",
              {mem_rd_en, 10'(mem_rd_addr), out_valid, out_data, out_last, busy, done}, 0);
        @(negedge clk);
        check("rst_no_done", done, 0);
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("rst_release_idle", {busy, done, out_valid}, 0);
        return;
      end
      if (k == 1) begin
        check("issue0_en", mem_rd_en, 1);
        check("issue0_addr", mem_rd_addr, 0);
        check("busy_run", busy, 1);
      end
      if (out_valid && first_v == 0) begin
        first_v = k;
        check("first_valid_latency", k, 3);
      end
      if (issued - beats > max_out) max_out = issued - beats;
      if (mem_rd_en) begin
        check("addr_seq", mem_rd_addr, issued);
        issued++;
      end
      if (mode == 1 && k >= 3 && k < 13) check("stall_hold", {out_valid, out_data}, {1'b1, 16'h100});
      if (done) begin
        dones++;
        fin = 1;
        check("done_timing", k, last_hs + 1);
        check("busy_in_done", busy, 0);
      end
      if (out_valid && out_ready) begin
        check("beat_data", out_data, 16'h100 + beats);
        check("beat_last", out_last, (beats == n - 1));
        if (out_last) lasts++;
        beats++;
        last_hs = k;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("beat_count", beats, n);
    check("issue_count", issued, n);
    check("last_count", lasts, 1);
    check("done_count", dones, 1);
    check("max_outstanding_le2", (max_out <= 2), 1);
    @(negedge clk);
    #1;
    check("idle_after_done", {busy, done, out_valid}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_5x5 = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_outs", {mem_rd_en, 10'(mem_rd_addr), out_valid, out_data, out_last, busy, done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    frame(1'b0, 0, 0);
    frame(1'b1, 0, 0);
    frame(1'b0, 1, 0);
    frame(1'b0, 2, 0);
    frame(1'b1, 2, 0);
    frame(1'b0, 0, 10);
    frame(1'b1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
